// File: rtl/alu_result_display_pkg.sv
// Shared constants for the ALU result display: op codes,
// active-low 7-segment glyphs, FSM state encoding.
package alu_disp_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [2:0] FUNC_ADD = 3'd0;
    localparam logic [2:0] FUNC_SUB = 3'd1;
    localparam logic [2:0] FUNC_NOT = 3'd2;
    localparam logic [2:0] FUNC_AND = 3'd3;
    localparam logic [2:0] FUNC_OR  = 3'd4;
    localparam logic [2:0] FUNC_XOR = 3'd5;
    localparam logic [2:0] FUNC_LT  = 3'd6;
    localparam logic [2:0] FUNC_EQ  = 3'd7;

    // {dp,g,f,e,d,c,b,a}, active-low, dp off
    localparam logic [7:0] GLY_0     = 8'hC0;
    localparam logic [7:0] GLY_1     = 8'hF9;
    localparam logic [7:0] GLY_2     = 8'hA4;
    localparam logic [7:0] GLY_3     = 8'hB0;
    localparam logic [7:0] GLY_4     = 8'h99;
    localparam logic [7:0] GLY_5     = 8'h92;
    localparam logic [7:0] GLY_6     = 8'h82;
    localparam logic [7:0] GLY_7     = 8'hF8;
    localparam logic [7:0] GLY_8     = 8'h80;
    localparam logic [7:0] GLY_9     = 8'h90;
    localparam logic [7:0] GLY_A     = 8'h88;
    localparam logic [7:0] GLY_B     = 8'h83;
    localparam logic [7:0] GLY_C     = 8'hC6;
    localparam logic [7:0] GLY_D     = 8'hA1;
    localparam logic [7:0] GLY_E     = 8'h86;
    localparam logic [7:0] GLY_F     = 8'h8E;
    localparam logic [7:0] GLY_DASH  = 8'hBF;
    localparam logic [7:0] GLY_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SHOW = 2'd2
    } state_e;

    // ADD/SUB results are sign-magnitude
    function automatic logic is_sm_op(input logic [2:0] func);
        return (func == FUNC_ADD) || (func == FUNC_SUB);
    endfunction

endpackage

// File: rtl/alu_result_display_if.sv
// ALU result valid/ready bundle.
// master = ALU side, slave = display side.
interface alu_result_display_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_func;
    logic [3:0] in_result;
    logic       in_c;
    logic       in_over;

    modport master (
        output in_valid, in_func, in_result, in_c, in_over,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_func, in_result, in_c, in_over,
        output in_ready
    );
endinterface

// File: rtl/alu_result_display_seg7_hex.sv
// Nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Ports: nib_i (4b value), seg_o (7b pattern).
module seg7_hex
    import alu_disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = GLY_BLANK[6:0];
        unique case (nib_i)
            4'h0: seg_o = GLY_0[6:0];
            4'h1: seg_o = GLY_1[6:0];
            4'h2: seg_o = GLY_2[6:0];
            4'h3: seg_o = GLY_3[6:0];
            4'h4: seg_o = GLY_4[6:0];
            4'h5: seg_o = GLY_5[6:0];
            4'h6: seg_o = GLY_6[6:0];
            4'h7: seg_o = GLY_7[6:0];
            4'h8: seg_o = GLY_8[6:0];
            4'h9: seg_o = GLY_9[6:0];
            4'hA: seg_o = GLY_A[6:0];
            4'hB: seg_o = GLY_B[6:0];
            4'hC: seg_o = GLY_C[6:0];
            4'hD: seg_o = GLY_D[6:0];
            4'hE: seg_o = GLY_E[6:0];
            4'hF: seg_o = GLY_F[6:0];
        endcase
    end

endmodule

// File: rtl/alu_result_display.sv
// Captures ALU results over valid/ready, holds each one for a minimum
// time and shows it on a 4-digit multiplexed active-low 7-seg display.
// Ports: clk, rst (sync, active-high), in_if (slave result bundle),
// seg_n {dp,g..a} active-low, an_n digit enables active-low.
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_CYCLES = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_result_display_if.slave   in_if,
    output logic [7:0]            seg_n,
    output logic [NUM_DIGITS-1:0] an_n
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_e          state_q;
    logic            in_ready_q;
    logic [HW-1:0]   hold_q;
    logic [2:0]      func_q;
    logic [3:0]      res_q;
    logic            c_q;
    logic            over_q;

    logic [PW-1:0]   pre_q;
    logic [IW-1:0]   idx_q;
    logic [7:0]      seg_q;
    logic [NUM_DIGITS-1:0] an_q;

    logic            fire;
    logic [3:0]      nib;
    logic [6:0]      hex7;
    logic [7:0]      seg_d;
    logic [NUM_DIGITS-1:0] an_d;

    assign fire           = in_if.in_valid && in_ready_q;
    assign in_if.in_ready = in_ready_q;
    assign seg_n          = seg_q;
    assign an_n           = an_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            hold_q     <= '0;
            func_q     <= '0;
            res_q      <= '0;
            c_q        <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q    <= ST_SHOW;
                        in_ready_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    in_ready_q <= 1'b1;
                    if (fire) begin
                        state_q    <= ST_HOLD;
                        in_ready_q <= 1'b0;
                        hold_q     <= '0;
                        func_q     <= in_if.in_func;
                        res_q      <= in_if.in_result;
                        c_q        <= in_if.in_c;
                        over_q     <= in_if.in_over;
                    end
                end
            endcase
        end
    end

    // d3 shows the op code, d0 the (possibly reduced) result value
    always_comb begin
        nib = {1'b0, func_q};
        if (idx_q == 2'd0) begin
            if (is_sm_op(func_q))
                nib = {1'b0, res_q[2:0]};
            else if (func_q == FUNC_LT || func_q == FUNC_EQ)
                nib = {3'b000, res_q[0]};
            else
                nib = res_q;
        end
    end

    seg7_hex u_hex (
        .nib_i (nib),
        .seg_o (hex7)
    );

    always_comb begin
        seg_d = {1'b1, hex7};
        an_d  = ~(NUM_DIGITS'(1) << idx_q);
        if (state_q == ST_IDLE) begin
            seg_d = GLY_DASH;
        end else begin
            case (idx_q)
                2'd2: seg_d = c_q ? GLY_C : GLY_BLANK;
                2'd1: begin
                    // negative zero keeps no minus sign
                    if (is_sm_op(func_q) && res_q[3] && |res_q[2:0])
                        seg_d = GLY_DASH;
                    else
                        seg_d = GLY_BLANK;
                end
                2'd0: seg_d[7] = ~over_q;
                default: ;
            endcase
        end
    end

    // an_n and seg_n come from the same idx_q so they never drift apart
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
            seg_q <= GLY_BLANK;
            an_q  <= '1;
        end else begin
            if (pre_q == SCAN_LAST) begin
                pre_q <= '0;
                idx_q <= idx_q + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Testbench for alu_result_display: vector table, hand sequences
// for hold/reset corners, and random results against a digit model.
module tb_alu_result_display;

    localparam int SCAN = 4;
    localparam int HOLD = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] seg_n;
    logic [3:0] an_n;

    alu_result_display_if bus ();

    alu_result_display #(
        .SCAN_DIV    (SCAN),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .in_if (bus),
        .seg_n (seg_n),
        .an_n  (an_n)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nbad = 0;

    logic [7:0] hexg [16];
    logic [7:0] seen [4];

    typedef struct {
        logic [2:0] f;
        logic [3:0] r;
        logic       c;
        logic       o;
        logic [7:0] e3, e2, e1, e0;
    } vec_t;

    vec_t tab [7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Digit model straight from the display rules
    function automatic logic [7:0] model(input int d, input int f,
        input int r, input int c, input int o);
        int mag;
        int v;
        bit sm;
        mag = r % 8;
        sm  = (f < 2);
        case (d)
            3: return hexg[f];
            2: return (c != 0) ? 8'hC6 : 8'hFF;
            1: return (sm && r >= 8 && mag != 0) ? 8'hBF : 8'hFF;
            default: begin
                v = sm ? mag : ((f < 6) ? r : r % 2);
                return (o != 0) ? (hexg[v] & 8'h7F) : hexg[v];
            end
        endcase
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic drive(input logic [2:0] f, input logic [3:0] r,
                         input logic c, input logic o);
        bus.in_valid  = 1'b1;
        bus.in_func   = f;
        bus.in_result = r;
        bus.in_c      = c;
        bus.in_over   = o;
    endtask

    // Collect each digit's pattern over a full scan rotation
    task automatic scan_digits();
        for (int k = 0; k < 4; k++) seen[k] = 8'h00;
        for (int i = 0; i < 4 * SCAN + 2; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                if (an_n == ~(4'b0001 << k)) seen[k] = seg_n;
        end
    endtask

    task automatic check_disp(input string t, input logic [7:0] e3,
        input logic [7:0] e2, input logic [7:0] e1, input logic [7:0] e0);
        scan_digits();
        chk({t, "_d3"}, {24'd0, seen[3]}, {24'd0, e3});
        chk({t, "_d2"}, {24'd0, seen[2]}, {24'd0, e2});
        chk({t, "_d1"}, {24'd0, seen[1]}, {24'd0, e1});
        chk({t, "_d0"}, {24'd0, seen[0]}, {24'd0, e0});
    endtask

    task automatic send(input string t, input logic [2:0] f,
        input logic [3:0] r, input logic c, input logic o);
        int low;
        wait_ready();
        drive(f, r, c, o);
        @(posedge clk);
        #1;
        chk({t, "_cap"}, {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        low = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.in_ready !== 1'b0) break;
            low++;
            @(negedge clk);
        end
        chk({t, "_hold"}, low, HOLD);
    endtask

    initial begin
        int low;
        hexg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        tab[0] = '{3'd0, 4'hB, 1'b0, 1'b0, 8'hC0, 8'hFF, 8'hBF, 8'hB0};
        tab[1] = '{3'd5, 4'hA, 1'b1, 1'b0, 8'h92, 8'hC6, 8'hFF, 8'h88};
        tab[2] = '{3'd1, 4'h8, 1'b0, 1'b1, 8'hF9, 8'hFF, 8'hFF, 8'h40};
        tab[3] = '{3'd6, 4'h3, 1'b0, 1'b0, 8'h82, 8'hFF, 8'hFF, 8'hF9};
        tab[4] = '{3'd2, 4'hF, 1'b1, 1'b1, 8'hA4, 8'hC6, 8'hFF, 8'h0E};
        tab[5] = '{3'd7, 4'h0, 1'b0, 1'b0, 8'hF8, 8'hFF, 8'hFF, 8'hC0};
        tab[6] = '{3'd4, 4'h8, 1'b0, 1'b0, 8'h99, 8'hFF, 8'hFF, 8'h80};

        bus.in_valid  = 1'b0;
        bus.in_func   = '0;
        bus.in_result = '0;
        bus.in_c      = 1'b0;
        bus.in_over   = 1'b0;

        // reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seg", {24'd0, seg_n}, 32'hFF);
        chk("rst_an", {28'd0, an_n}, 32'hF);
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", {31'd0, bus.in_ready}, 32'd1);
        check_disp("idle", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

        // vector table
        for (int i = 0; i < 7; i++) begin
            send($sformatf("vec%0d", i), tab[i].f, tab[i].r,
                 tab[i].c, tab[i].o);
            check_disp($sformatf("vec%0d", i), tab[i].e3, tab[i].e2,
                       tab[i].e1, tab[i].e0);
        end

        // valid held through HOLD: taken on first ready edge only
        wait_ready();
        drive(3'd3, 4'h5, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("held_cap", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        drive(3'd4, 4'hC, 1'b1, 1'b0);
        low = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.in_ready !== 1'b0) break;
            low++;
            @(negedge clk);
        end
        chk("held_low", low, HOLD);
        @(posedge clk);
        #1;
        chk("held_retake", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_ready();
        check_disp("held", 8'h99, 8'hC6, 8'hFF, 8'hC6);

        // random results against the model
        for (int n = 0; n < 20; n++) begin
            int f, r, c, o;
            f = int'($urandom_range(0, 7));
            r = int'($urandom_range(0, 15));
            c = int'($urandom_range(0, 1));
            o = int'($urandom_range(0, 1));
            send($sformatf("rnd%0d", n), 3'(f), 4'(r), 1'(c), 1'(o));
            check_disp($sformatf("rnd%0d", n), model(3, f, r, c, o),
                       model(2, f, r, c, o), model(1, f, r, c, o),
                       model(0, f, r, c, o));
        end

        // reset pulse mid-HOLD
        wait_ready();
        drive(3'd0, 4'h9, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_seg", {24'd0, seg_n}, 32'hFF);
        chk("mrst_an", {28'd0, an_n}, 32'hF);
        chk("mrst_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk($sformatf("scan_an%0d", k), {28'd0, an_n},
                {28'd0, ~(4'b0001 << (((k - 1) / SCAN) % 4))});
            chk($sformatf("scan_seg%0d", k), {24'd0, seg_n}, 32'hBF);
            chk($sformatf("scan_rdy%0d", k), {31'd0, bus.in_ready},
                32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nbad);
        $finish;
    end

endmodule
